// File: rtl/limn2600_mem_pkg.sv
// Shared types and constants for the limn2600 memory arbiter.
// Holds FSM states, port ids and the default RAM bank selector.
package limn2600_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [15:0] RAM_HI_DEFAULT = 16'h0000;

    // Misaligned access, or a write outside the RAM bank.
    function automatic logic acc_err(
        input logic [31:0] addr,
        input logic        we,
        input logic [15:0] ram_hi
    );
        return (addr[1:0] != 2'b00) ||
               (we && (addr[31:16] != ram_hi));
    endfunction

endpackage

// File: rtl/limn2600_rr_arb2.sv
// Two-way round-robin picker for the memory arbiter.
// Bit 0 is the I port, bit 1 the D port.
module limn2600_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_d_q;
    logic last_d_d;

    // Single requester wins; a tie goes to the port not granted last.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_d_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember which port was granted when the grant is taken.
    always_comb begin
        last_d_d = last_d_q;
        if (advance && (grant != 2'b00)) begin
            last_d_d = grant[1];
        end
    end

    // Reset makes D the "last" winner, so I wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end

endmodule

// File: rtl/limn2600_mem_arbiter.sv
// Arbiter between instruction-fetch and data ports onto one DRAM.
// One transaction at a time: grant, ACCESS, RESP, then ack.
module limn2600_mem_arbiter
    import limn2600_mem_pkg::*;
#(
    parameter logic [15:0] RAM_HI = RAM_HI_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_rdy,
    output logic        busy
);

    state_e      state_q, state_d;
    port_e       port_q, port_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        i_err_q, i_err_d;
    logic        d_ack_q, d_ack_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        d_err_q, d_err_d;

    logic [1:0]  elig;
    logic [1:0]  grant;
    logic        go;

    // A port being acked this cycle is finishing, not requesting.
    assign elig = {d_req & ~d_ack_q, i_req & ~i_ack_q};
    assign go   = (state_q == IDLE) && mem_rdy;

    limn2600_rr_arb2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .advance (go),
        .grant   (grant)
    );

    // Next-state and registered-output computation for the FSM.
    always_comb begin
        state_d     = state_q;
        port_d      = port_q;
        we_d        = we_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        i_err_d     = i_err_q;
        d_ack_d     = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_err_d     = d_err_q;
        unique case (state_q)
            IDLE: begin
                if (go && (grant != 2'b00)) begin
                    state_d = ACCESS;
                    if (grant[1]) begin
                        port_d      = PORT_D;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        we_d        = d_we;
                        err_d       = acc_err(d_addr, d_we, RAM_HI);
                    end else begin
                        port_d      = PORT_I;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        we_d        = 1'b0;
                        err_d       = acc_err(i_addr, 1'b0, RAM_HI);
                    end
                    mem_we_d = we_d && !err_d;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (port_q == PORT_D) begin
                    d_ack_d   = 1'b1;
                    d_err_d   = err_q;
                    d_rdata_d = (we_q || err_q) ? '0 : mem_data_out;
                end else begin
                    i_ack_d   = 1'b1;
                    i_err_d   = err_q;
                    i_rdata_d = err_q ? '0 : mem_data_out;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All FSM state and outputs; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            port_q      <= PORT_I;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_rdata_q   <= '0;
            d_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            port_q      <= port_d;
            we_q        <= we_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ack_q     <= i_ack_d;
            i_rdata_q   <= i_rdata_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_wdata_q;
    assign i_ack       = i_ack_q;
    assign i_rdata     = i_rdata_q;
    assign i_err       = i_err_q;
    assign d_ack       = d_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_err       = d_err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: doc/limn2600_mem_arbiter.md
LIMN2600_MEM_ARBITER -- requirements
Module: limn2600_mem_arbiter

Interface
REQ-001 Parameter SHALL be: RAM_HI, 16'h0000, value of addr[31:16] that selects the writable RAM bank; any other value selects the read-only ROM bank.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 i_req  input  1  instruction-fetch read request; held until i_ack.
REQ-005 i_addr  input  32  instruction-fetch byte address.
REQ-006 i_ack  output  1  one-cycle pulse; i_rdata and i_err are valid in this cycle.
REQ-007 i_rdata  output  32  fetched word.
REQ-008 i_err  output  1  misaligned fetch.
REQ-009 d_req  input  1  data-port request; held until d_ack.
REQ-010 d_we  input  1  data-port write when 1, read when 0.
REQ-011 d_addr  input  32  data-port byte address.
REQ-012 d_wdata  input  32  data-port write word.
REQ-013 d_ack  output  1  one-cycle pulse; d_rdata and d_err are valid in this cycle.
REQ-014 d_rdata  output  32  data-port read word.
REQ-015 d_err  output  1  misaligned access, or write to the ROM region.
REQ-016 mem_we  output  1  DRAM write enable.
REQ-017 mem_addr  output  32  DRAM address.
REQ-018 mem_data_in  output  32  DRAM write data.
REQ-019 mem_data_out  input  32  DRAM read data; registered, valid one cycle after the address is sampled.
REQ-020 mem_rdy  input  1  DRAM ready.
REQ-021 busy  output  1  high in every state other than IDLE.

Function
REQ-022 The FSM SHALL have three states: IDLE, ACCESS and RESP. Transitions:
- IDLE to ACCESS on a grant.
- ACCESS to RESP unconditionally.
- RESP to IDLE unconditionally.
REQ-023 A grant in IDLE SHALL require mem_rdy=1. With mem_rdy=0 the arbiter stays in IDLE and issues no DRAM activity.
REQ-024 Eligible ports: a port whose ack is high in the current cycle SHALL be treated as not requesting.
REQ-025 Arbitration between the two ports SHALL be round-robin:
- If only one port is eligible, that port is granted.
- If both are eligible, the port not granted last time wins.
- After reset, a tie goes to the I port.
REQ-026 On the grant edge, the arbiter SHALL latch the following into registers:
- granted port id,
- address into mem_addr,
- write data into mem_data_in,
- write flag,
- error flag.
REQ-027 Error flag: addr[1:0]!=0, or a data write with addr[31:16]!=RAM_HI.
REQ-028 mem_we SHALL be 1 only in ACCESS, only for a granted write with error flag 0, and for exactly one cycle per transaction.
REQ-029 mem_addr and mem_data_in SHALL hold their values throughout ACCESS and RESP.
REQ-030 On the RESP to IDLE edge, the arbiter SHALL:
- load the granted port's rdata from mem_data_out (0 for writes and for errored requests),
- load its err from the error flag,
- set its ack.
REQ-031 ack SHALL be high for exactly one cycle. Grant-cycle to ack-cycle latency is 3 cycles, giving 1 transaction per 3 cycles at most.
REQ-032 A request deasserted before its grant SHALL be dropped without ack. Changes to inputs after the grant SHALL NOT affect the transaction in flight.
REQ-033 Only one transaction SHALL be outstanding at a time. The arbiter SHALL NOT issue a DRAM access in RESP.

Reset
REQ-034 While rst=1, all of the following SHALL be forced immediately (asynchronously):
- state = IDLE,
- mem_we = 0,
- mem_addr = 0,
- mem_data_in = 0,
- i_ack = d_ack = 0,
- i_rdata = d_rdata = 0,
- i_err = d_err = 0,
- busy = 0,
- round-robin pointer = "I first".
REQ-035 Reset during ACCESS or RESP SHALL abandon the transaction without ack. A write caught in ACCESS is not committed, because mem_we drops before the next edge.

Structure
REQ-036 The shared package limn2600_mem_pkg SHALL hold:
- the state enum (IDLE, ACCESS, RESP),
- the port-id typedef (PORT_I, PORT_D),
- the default RAM_HI constant.
REQ-037 The two-way round-robin picker SHALL be the sub-module limn2600_rr_arb2:
- inputs: req[1:0], advance,
- output: one-hot grant[1:0],
- contains the pointer register.

Verification
REQ-038 mem_rdy=0 for 4 cycles with i_req=1 and i_addr=0x00010000 -> no mem activity. After mem_rdy=1: grant, i_ack 3 cycles later, i_rdata = rom[0], i_err=0.
REQ-039 d_req=1, d_we=1, d_addr=0x00000010, d_wdata=0xDEADBEEF, then a read of the same address -> mem_we high for exactly 1 cycle, then d_rdata=0xDEADBEEF.
REQ-040 i_req and d_req held high continuously from reset -> grants alternate I, D, I, D; each ack arrives 3 cycles after its grant.
REQ-041 d_we=1, d_addr=0x00010004 -> mem_we stays 0, d_ack with d_err=1. d_addr=0x00000002 read -> d_err=1, d_rdata=0.
REQ-042 rst asserted in the ACCESS cycle of a write of 0x12345678 to 0x00000020 -> mem_we drops immediately, no ack. A later read of 0x00000020 returns the previous contents.
